// File: rtl/dw03_slot_grant_seq_if.sv
// Slot-counter and client-bank signals of the slot grant sequencer, grouped as one bus.
// slave is the sequencer's view of the bus; master is the view of whatever drives it.
interface dw03_slot_grant_seq_if #(
  parameter int width = 3
);
  localparam int N = 1 << width;

  logic           cen_in;
  logic [N-1:0]   slot_dec;
  logic           tercnt;
  logic [N-1:0]   req;
  logic           ack;
  logic           cen_out;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic           frame_end;
  logic           timeout;
  logic           dec_err;
  logic [width:0] frame_served;

  modport slave (
    input  cen_in, slot_dec, tercnt, req, ack,
    output cen_out, gnt, gnt_valid, frame_end, timeout, dec_err, frame_served
  );

  modport master (
    output cen_in, slot_dec, tercnt, req, ack,
    input  cen_out, gnt, gnt_valid, frame_end, timeout, dec_err, frame_served
  );
endinterface

// File: rtl/dw03_slot_grant_seq.sv
// Turns each decoded counter slot into a req/ack grant and stalls the counter while a grant is open.
// Optional per-frame served-ack statistics: define DW03_SLOT_GRANT_STATS_EN.
//
// state | meaning
// IDLE  | counter may advance; a slot is consumed on any cycle with cen_in=1
// GRANT | one client holds gnt; waiting for ack or for the timeout to expire
module dw03_slot_grant_seq #(
  parameter int width = 3,
  parameter int tmo   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  dw03_slot_grant_seq_if.slave     bus
);
  localparam int N = 1 << width;
  localparam logic [N-1:0] ONE_N    = N'(1);
  localparam logic [7:0]   TMO_LAST = 8'(tmo - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic         frame_end_q, frame_end_d;
  logic         timeout_q, timeout_d;
  logic         dec_err_q, dec_err_d;
  logic [7:0]   tmo_cnt_q, tmo_cnt_d;
`ifdef DW03_SLOT_GRANT_STATS_EN
  localparam logic [width:0] SERVED_MAX = (width+1)'(N);
  localparam logic [width:0] SERVED_ONE = (width+1)'(1);
  logic [width:0] served_cnt_q, served_cnt_d;
  logic [width:0] frame_served_q, frame_served_d;
`endif

  logic one_hot;
  logic slot_hit;

  assign one_hot  = (bus.slot_dec != '0) && ((bus.slot_dec & (bus.slot_dec - ONE_N)) == '0);
  assign slot_hit = one_hot && ((bus.req & bus.slot_dec) != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      gnt_valid_q    <= 1'b0;
      frame_end_q    <= 1'b0;
      timeout_q      <= 1'b0;
      dec_err_q      <= 1'b0;
      tmo_cnt_q      <= '0;
`ifdef DW03_SLOT_GRANT_STATS_EN
      served_cnt_q   <= '0;
      frame_served_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      gnt_valid_q    <= gnt_valid_d;
      frame_end_q    <= frame_end_d;
      timeout_q      <= timeout_d;
      dec_err_q      <= dec_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
`ifdef DW03_SLOT_GRANT_STATS_EN
      served_cnt_q   <= served_cnt_d;
      frame_served_q <= frame_served_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    gnt_valid_d    = gnt_valid_q;
    frame_end_d    = 1'b0;
    timeout_d      = 1'b0;
    dec_err_d      = dec_err_q;
    tmo_cnt_d      = tmo_cnt_q;
`ifdef DW03_SLOT_GRANT_STATS_EN
    served_cnt_d   = served_cnt_q;
    frame_served_d = frame_served_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cen_in) begin
          if (!one_hot) begin
            dec_err_d = 1'b1;
          end else if (slot_hit) begin
            gnt_d       = bus.slot_dec;
            gnt_valid_d = 1'b1;
            tmo_cnt_d   = '0;
            state_d     = GRANT;
          end
          // Frame accounting runs even for skipped or malformed terminal slots.
          if (bus.tercnt) begin
            frame_end_d    = 1'b1;
`ifdef DW03_SLOT_GRANT_STATS_EN
            frame_served_d = served_cnt_q;
            served_cnt_d   = '0;
`endif
          end
        end
      end
      GRANT: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (bus.ack) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef DW03_SLOT_GRANT_STATS_EN
          if (served_cnt_q != SERVED_MAX) begin
            served_cnt_d = served_cnt_q + SERVED_ONE;
          end
`endif
        end else if (tmo_cnt_q == TMO_LAST) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cen_out   = bus.cen_in & (state_q == IDLE);
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.frame_end = frame_end_q;
  assign bus.timeout   = timeout_q;
  assign bus.dec_err   = dec_err_q;
`ifdef DW03_SLOT_GRANT_STATS_EN
  assign bus.frame_served = frame_served_q;
`else
  assign bus.frame_served = '0;
`endif
endmodule

// File: tb/tb_dw03_slot_grant_seq.sv
// Bench for dw03_slot_grant_seq: directed scenarios plus random traffic, with a queue of
// expected grant / timeout / frame-end events compared by an independent output monitor.
module tb_dw03_slot_grant_seq;
  localparam int WIDTH = 3;
  localparam int TMO   = 16;
  localparam int NCLI  = 1 << WIDTH;
`ifdef DW03_SLOT_GRANT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int K_GNT = 1;
  localparam int K_FRM = 2;
  localparam int K_TMO = 3;

  typedef struct {
    int kind;
    int val;
  } evt_t;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  evt_t sb[$];

  // reference model state, in terms of the grant protocol
  bit m_busy    = 1'b0;
  int m_visible = 0;
  int m_served  = 0;
  bit m_dec_err = 1'b0;

  dw03_slot_grant_seq_if #(.width(WIDTH)) bus ();

  dw03_slot_grant_seq #(.width(WIDTH), .tmo(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic expect_evt(input string name, input int kind, input int val);
    evt_t e;
    if (sb.size() == 0) begin
      chk({name, "_unexpected"}, kind, 0);
    end else begin
      e = sb.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_value"}, val, e.val);
    end
  endtask

  // Monitor: every new grant, frame-end pulse and timeout pulse must match the next expected event.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.gnt_valid && !prev_valid) expect_evt("grant", K_GNT, int'(bus.gnt));
      if (bus.frame_end) expect_evt("frame_end", K_FRM, int'(bus.frame_served));
      if (bus.timeout) expect_evt("timeout", K_TMO, 0);
      prev_valid = bus.gnt_valid;
    end
  end

  // One clock cycle: drive inputs at the falling edge, predict what the next rising edge does.
  task automatic step(input logic c, input logic [7:0] s, input logic t,
                      input logic [7:0] r, input logic a);
    bus.cen_in   = c;
    bus.slot_dec = s;
    bus.tercnt   = t;
    bus.req      = r;
    bus.ack      = a;
    #1;
    chk("cen_out", int'(bus.cen_out), int'(c & !m_busy));
    chk("gnt_valid", int'(bus.gnt_valid), int'(m_busy));
    chk("dec_err", int'(bus.dec_err), int'(m_dec_err));
    if (!m_busy) begin
      if (c) begin
        if ($countones(s) != 1) begin
          m_dec_err = 1'b1;
        end else if ((r & s) != 8'h00) begin
          push(K_GNT, int'(s));
          m_busy    = 1'b1;
          m_visible = 0;
        end
        if (t) begin
          push(K_FRM, STATS ? m_served : 0);
          m_served = 0;
        end
      end
    end else begin
      m_visible++;
      if (a) begin
        m_busy = 1'b0;
        if (m_served < NCLI) m_served++;
      end else if (m_visible == TMO) begin
        push(K_TMO, 0);
        m_busy = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_gnt"}, int'(bus.gnt), 0);
    chk({tag, "_gnt_valid"}, int'(bus.gnt_valid), 0);
    chk({tag, "_frame_end"}, int'(bus.frame_end), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
    chk({tag, "_dec_err"}, int'(bus.dec_err), 0);
    chk({tag, "_frame_served"}, int'(bus.frame_served), 0);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk_cleared("async_reset");
    m_busy    = 1'b0;
    m_visible = 0;
    m_served  = 0;
    m_dec_err = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int         r;
    int         i0;

    reset        = 1'b1;
    bus.cen_in   = 1'b0;
    bus.slot_dec = '0;
    bus.tercnt   = 1'b0;
    bus.req      = '0;
    bus.ack      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cleared("reset");
    reset = 1'b0;

    // grant, ack one cycle later
    step(1'b1, 8'h04, 1'b0, 8'h04, 1'b0);
    chk("first_gnt", int'(bus.gnt), 8'h04);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("ack_gnt_cleared", int'(bus.gnt), 0);
    // slot whose client is idle is skipped
    step(1'b1, 8'h10, 1'b0, 8'h01, 1'b0);
    step(1'b1, 8'h10, 1'b0, 8'h01, 1'b0);
    // grant withdrawn after TMO visible cycles
    step(1'b1, 8'h01, 1'b0, 8'h01, 1'b0);
    for (int k = 0; k < TMO; k++) step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    // ack on the final cycle wins over timeout
    step(1'b1, 8'h02, 1'b0, 8'h02, 1'b0);
    for (int k = 0; k < TMO - 1; k++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // two full frames, every slot requested and acked
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NCLI; k++) begin
        s = 8'd1 << k;
        step(1'b1, s, (k == NCLI - 1), 8'hFF, 1'b0);
        if (k == NCLI - 1) chk("frame_served_directed", int'(bus.frame_served),
                               STATS ? ((f == 0) ? NCLI - 1 : NCLI) : 0);
        step(1'b0, 8'h00, 1'b0, 8'hFF, 1'b1);
      end
    end

    // malformed decode words set a sticky error
    step(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'h18, 1'b0, 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h01, 1'b0, 8'hFF, 1'b0);
    chk("dec_err_sticky", int'(bus.dec_err), 1);

    // reset in the middle of a grant
    step(1'b1, 8'h20, 1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    do_reset();
    for (int k = 0; k < TMO + 4; k++) step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      r  = int'($urandom_range(0, 39));
      i0 = int'($urandom_range(0, NCLI - 1));
      if (r == 0) s = 8'h00;
      else if (r == 1) s = (8'd1 << i0) | (8'd1 << ((i0 + 1 + int'($urandom_range(0, 6))) % NCLI));
      else s = 8'd1 << i0;
      step(($urandom_range(0, 3) != 0), s,
           (s == 8'h80) || ($urandom_range(0, 15) == 0),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 9) == 0));
    end
    for (int k = 0; k < TMO + 2; k++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
